// File: rtl/alu_decode_stage.sv
// Registered ALU-operation decoder for RV32I/RV64I (+M), behind a valid/ready
// handshake with a main register and a one-entry skid register.
module alu_decode_stage #(
  parameter int XLEN  = 32,
  parameter int HAS_M = 1,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_op,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
    OP_XOR    = 5'd4,  OP_SLT    = 5'd5,  OP_SLTU  = 5'd6,  OP_SLL   = 5'd7,
    OP_SRL    = 5'd8,  OP_SRA    = 5'd9,  OP_MUL   = 5'd10, OP_MULH  = 5'd11,
    OP_MULHSU = 5'd12, OP_MULHU  = 5'd13, OP_DIV   = 5'd14, OP_DIVU  = 5'd15,
    OP_REM    = 5'd16, OP_REMU   = 5'd17, OP_ADDW  = 5'd18, OP_SUBW  = 5'd19,
    OP_SLLW   = 5'd20, OP_SRLW   = 5'd21, OP_SRAW  = 5'd22, OP_MULW  = 5'd23,
    OP_DIVW   = 5'd24, OP_DIVUW  = 5'd25, OP_REMW  = 5'd26, OP_REMUW = 5'd27
  } alu_op_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shift_ok;
  logic       sra_ok;
  logic       unused_fields;
  alu_op_e    dec_op;
  logic       dec_illegal;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  // RV64 immediate shifts use a 6-bit shamt, so bit 25 belongs to the amount.
  assign shift_ok = (XLEN == 64) ? (in_instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
  assign sra_ok   = (XLEN == 64) ? (in_instr[31:26] == 6'b010000) : (f7 == 7'b0100000);
  assign unused_fields = ^{in_instr[24:15], in_instr[11:7]};

  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec_op = OP_SRA;
        end else if (f7 == 7'b0000001 && HAS_M != 0) begin
          dec_op = alu_op_e'(5'd10 + {2'b00, f3});
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        case (f3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b001: begin
            if (shift_ok) dec_op = OP_SLL;
            else          dec_illegal = 1'b1;
          end
          3'b101: begin
            if (shift_ok)    dec_op = OP_SRL;
            else if (sra_ok) dec_op = OP_SRA;
            else             dec_illegal = 1'b1;
          end
          default: dec_op = OP_AND;
        endcase
      end
      OPC_OP_32: begin
        if (XLEN != 64) begin
          dec_illegal = 1'b1;
        end else if (f7 == 7'b0000000 && f3 == 3'b000) begin
          dec_op = OP_ADDW;
        end else if (f7 == 7'b0000000 && f3 == 3'b001) begin
          dec_op = OP_SLLW;
        end else if (f7 == 7'b0000000 && f3 == 3'b101) begin
          dec_op = OP_SRLW;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec_op = OP_SUBW;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec_op = OP_SRAW;
        end else if (f7 == 7'b0000001 && HAS_M != 0 && f3 == 3'b000) begin
          dec_op = OP_MULW;
        end else if (f7 == 7'b0000001 && HAS_M != 0 && f3[2]) begin
          // DIVW..REMUW sit contiguously at 24..27 for f3 100..111.
          dec_op = alu_op_e'(5'd20 + {2'b00, f3});
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM32: begin
        if (XLEN != 64)                            dec_illegal = 1'b1;
        else if (f3 == 3'b000)                     dec_op = OP_ADDW;
        else if (f3 == 3'b001 && f7 == 7'b0000000) dec_op = OP_SLLW;
        else if (f3 == 3'b101 && f7 == 7'b0000000) dec_op = OP_SRLW;
        else if (f3 == 3'b101 && f7 == 7'b0100000) dec_op = OP_SRAW;
        else                                       dec_illegal = 1'b1;
      end
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC:
        dec_op = OP_ADD;
      default: dec_illegal = 1'b1;
    endcase
  end

  logic             main_valid, skid_valid;
  logic [4:0]       main_op, skid_op;
  logic             main_ill, skid_ill;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             accept, deliver;

  assign in_ready    = !skid_valid;
  assign accept      = in_valid && !skid_valid;
  assign deliver     = main_valid && out_ready;
  assign out_valid   = main_valid;
  assign out_op      = main_op;
  assign out_illegal = main_ill;
  assign out_tag     = main_tag;

  // The skid only ever fills while main is stalled, so it always holds the younger entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid  <= 1'b0;
      main_op     <= '0;
      main_ill    <= 1'b0;
      main_tag    <= '0;
      skid_valid  <= 1'b0;
      skid_op     <= '0;
      skid_ill    <= 1'b0;
      skid_tag    <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (skid_valid) begin
        if (out_ready) begin
          main_op    <= skid_op;
          main_ill   <= skid_ill;
          main_tag   <= skid_tag;
          skid_valid <= 1'b0;
        end
      end else if (accept && (!main_valid || out_ready)) begin
        main_valid <= 1'b1;
        main_op    <= dec_op;
        main_ill   <= dec_illegal;
        main_tag   <= in_tag;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_op    <= dec_op;
        skid_ill   <= dec_illegal;
        skid_tag   <= in_tag;
      end else if (deliver) begin
        main_valid <= 1'b0;
      end
      if (deliver && main_ill && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered, parametrised ALU-operation decode stage between fetch and execute. Decodes a raw 32-bit RISC-V instruction into the team's 5-bit ALU operation code, covering RV32I/RV64I and, optionally, the M extension including the RV64 W-forms. Replaces unknown-value outputs with an explicit illegal flag. Sits behind a valid/ready handshake with a 2-entry skid buffer, so it sustains one instruction per cycle under backpressure.

## Interface
- XLEN, 32: 32 or 64; 64 enables the OP-32/OP-IMM-32 opcodes and 6-bit shamt checks.
- HAS_M, 1: 1 decodes funct7=0000001 as M extension; 0 makes those encodings illegal.
- TAG_W, 8: width of the sideband tag carried alongside each instruction.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; equals skid entry empty.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband; passed through unchanged.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- out_op  out  5  ALU operation code.
- out_illegal  out  1  encoding not supported for this XLEN/HAS_M.
- out_tag  out  TAG_W  tag of the presented entry.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions delivered.

## Operation
- Op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17, ADDW 18, SUBW 19, SLLW 20, SRLW 21, SRAW 22, MULW 23, DIVW 24, DIVUW 25, REMW 26, REMUW 27.
- OP (0110011):
  - funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: f3 000 SUB, 101 SRA.
  - funct7=0000001 with HAS_M: f3 000..111 map to MUL..REMU in order.
  - Anything else is illegal.
- OP-IMM (0010011): f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 001 SLL and 101 SRL require instr[31:25]=0 (XLEN=32) or instr[31:26]=0 (XLEN=64).
  - 101 SRA requires instr[31:25]=0100000 (32) or instr[31:26]=010000 (64).
  - Anything else is illegal.
- OP-32 (0111011), XLEN=64 only:
  - funct7=0000000: f3 000 ADDW, 001 SLLW, 101 SRLW.
  - funct7=0100000: f3 000 SUBW, 101 SRAW.
  - funct7=0000001 with HAS_M: f3 000 MULW, 100 DIVW, 101 DIVUW, 110 REMW, 111 REMUW.
  - Anything else is illegal.
- OP-IMM-32 (0011011), XLEN=64 only: f3 000 ADDW; 001 SLLW and 101 SRLW need funct7=0; 101 SRAW needs funct7=0100000.
- Load 0000011, store 0100011, branch 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111 all decode to ADD.
- Any other opcode, or any 64-only opcode when XLEN=32, is illegal.
- Illegal entries carry out_op=0 and out_illegal=1, and still flow through the pipeline in order.
- Buffer: main register drives out_*; skid register catches an input accepted while the main register is stalled. On out_ready, skid moves into main.
- illegal_cnt increments on each out_valid&&out_ready&&out_illegal handshake and saturates at all-ones.

## Timing
- Reset: out_valid=0, out_op=0, out_illegal=0, out_tag=0, illegal_cnt=0, skid empty, so in_ready=1 during and after reset.
- Latency: an instruction accepted at edge N is presented at N+1 (out_valid=1) when the stage was empty.
- Throughput: 1/cycle with out_ready held high; in_ready stays 1.
- Handshake:
  - Transfer occurs on valid&&ready at the rising edge.
  - out_* stay stable while out_valid&&!out_ready.
  - in_ready never depends combinationally on in_valid.
- Stall: with main occupied and out_ready=0, one more input goes to skid, then in_ready=0 the next cycle. Release re-asserts in_ready one cycle after the skid drains.
- Simultaneous accept and deliver with main full, skid empty: main takes the new entry and skid stays empty.
- Flush: at the edge, out_valid=0, skid is cleared, and a concurrent input is dropped. Flush has priority over all handshakes; illegal_cnt is unaffected.
- Reset mid-stall asynchronously clears all state; entries are lost.

## Test plan
- Reset with XLEN=64, HAS_M=1: out_valid=0, in_ready=1, illegal_cnt=0. Then in_instr=0x40B50533 (SUB), tag 0x11 -> next cycle out_op=1, illegal=0, tag 0x11.
- Stream 0x02B50533 (MUL), 0x02B5053B (MULW), 0x4015551B (SRAIW) with out_ready=1 -> ops 10, 23, 22 on consecutive cycles.
- XLEN=32: 0x0015051B -> illegal=1, op=0, illegal_cnt=1. Also 0x41F55513 (SRAI shamt 31) -> op 9.
- HAS_M=0: 0x02B50533 -> illegal; 0xFFFFFFFF -> illegal; illegal_cnt=2 after both handshakes.
- Backpressure: out_ready=0 while 3 instructions are offered -> 2 accepted, in_ready=0. Then out_ready=1 -> delivered in order with no loss or duplication.
- Flush with 2 buffered entries and in_valid=1 -> out_valid=0 the next cycle, no stale entry emitted; counter at all-ones stays saturated after another illegal.
